data_mem_ctrl: RTL and testbench

- MEM-stage data-memory controller; the consuming end of the ID-stage memory control signals (read/write flags, sign-extend flag, byte-select, store data).
- Checks alignment, maps the access onto byte lanes and runs a req/ack handshake with a multi-cycle data-memory bus.
- Stalls the pipeline until the bus completes, then returns aligned, extended load data to write-back.

---
 rtl/data_mem_ctrl_pkg.sv | 26 ++
 rtl/data_mem_ctrl_lane_align.sv | 67 ++++++
 rtl/data_mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Module   : data_mem_ctrl_pkg
// Brief    : Shared widths, mem_sel encodings and FSM states for the data-memory
//            controller and its lane aligner.
// Revision : 1.0 - initial release
// =============================================================================
package data_mem_ctrl_pkg;

   localparam int DATA_BUS    = 32;
   localparam int MEM_SEL_BUS = 4;

   localparam logic [MEM_SEL_BUS-1:0] SEL_BYTE = 4'b0001;
   localparam logic [MEM_SEL_BUS-1:0] SEL_HALF = 4'b0011;
   localparam logic [MEM_SEL_BUS-1:0] SEL_WORD = 4'b1111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic logic sel_is_legal(input logic [MEM_SEL_BUS-1:0] sel);
      return (sel == SEL_BYTE) || (sel == SEL_HALF) || (sel == SEL_WORD);
   endfunction

endpackage : data_mem_ctrl_pkg
`default_nettype wire

// File: rtl/data_mem_ctrl_lane_align.sv
`default_nettype none
// =============================================================================
// Module   : mem_lane_align
// Brief    : Combinational little-endian lane mapping: store byte enables and
//            replication, load lane extraction with sign/zero extension.
// Revision : 1.0 - initial release
// =============================================================================
module mem_lane_align
   import data_mem_ctrl_pkg::*;
(
   input  logic [MEM_SEL_BUS-1:0] st_sel,
   input  logic [1:0]             st_lane,
   input  logic [DATA_BUS-1:0]    st_data,
   output logic [3:0]             st_be,
   output logic [DATA_BUS-1:0]    st_wdata,
   output logic                   st_misaligned,
   input  logic [MEM_SEL_BUS-1:0] ld_sel,
   input  logic [1:0]             ld_lane,
   input  logic                   ld_sign_ext,
   input  logic [DATA_BUS-1:0]    ld_raw,
   output logic [DATA_BUS-1:0]    ld_data
);

   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;

   always_comb begin
      st_be         = 4'b0000;
      st_wdata      = '0;
      st_misaligned = 1'b0;
      case (st_sel)
         SEL_BYTE: begin
            st_be    = 4'b0001 << st_lane;
            st_wdata = {4{st_data[7:0]}};
         end
         SEL_HALF: begin
            st_be         = 4'b0011 << st_lane;
            st_wdata      = {2{st_data[15:0]}};
            st_misaligned = st_lane[0];
         end
         SEL_WORD: begin
            st_be         = 4'b1111;
            st_wdata      = st_data;
            st_misaligned = |st_lane;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (ld_lane)
         2'd0:    w_ld_byte = ld_raw[7:0];
         2'd1:    w_ld_byte = ld_raw[15:8];
         2'd2:    w_ld_byte = ld_raw[23:16];
         default: w_ld_byte = ld_raw[31:24];
      endcase
      w_ld_half = ld_lane[1] ? ld_raw[31:16] : ld_raw[15:0];

      case (ld_sel)
         SEL_BYTE: ld_data = {{24{ld_sign_ext & w_ld_byte[7]}}, w_ld_byte};
         SEL_HALF: ld_data = {{16{ld_sign_ext & w_ld_half[15]}}, w_ld_half};
         default:  ld_data = ld_raw;
      endcase
   end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : data_mem_ctrl
// Brief    : MEM-stage data-memory controller with req/ack bus handshake.
//            Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_read_flag,
   input  logic                  mem_write_flag,
   input  logic                  mem_sign_ext_flag,
   input  logic [3:0]            mem_sel,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_write_data,
   output logic                  stall_req,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_valid,
   output logic                  addr_error,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [3:0]            bus_be,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_ack,
   input  logic [DATA_WIDTH-1:0] bus_rdata
);

   if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
      $error("data_mem_ctrl: DATA_WIDTH must be 32 and TIMEOUT_CYCLES >= 1");
   end

   logic [1:0]             r_state;
   logic [DATA_WIDTH-1:0]  r_load_data;
   logic                   r_load_valid;
   logic                   r_addr_error;
   logic                   r_bus_we;
   logic [ADDR_WIDTH-1:0]  r_bus_addr;
   logic [3:0]             r_bus_be;
   logic [DATA_WIDTH-1:0]  r_bus_wdata;
   logic [MEM_SEL_BUS-1:0] r_sel;
   logic [1:0]             r_lane;
   logic                   r_sign;

   logic [3:0]             w_be;
   logic [DATA_WIDTH-1:0]  w_wdata;
   logic [DATA_WIDTH-1:0]  w_ld_data;
   logic                   w_misaligned;
   logic                   w_access;
   logic                   w_go;

`ifdef MEM_TIMEOUT_EN
   localparam int                C_TMO_W    = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                              $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [C_TMO_W-1:0] c_tmo_last = C_TMO_W'(TIMEOUT_CYCLES - 1);
   logic [C_TMO_W-1:0]           r_tmo_cnt;
`endif

   mem_lane_align u_lane_align (
      .st_sel        (mem_sel),
      .st_lane       (mem_addr[1:0]),
      .st_data       (mem_write_data),
      .st_be         (w_be),
      .st_wdata      (w_wdata),
      .st_misaligned (w_misaligned),
      .ld_sel        (r_sel),
      .ld_lane       (r_lane),
      .ld_sign_ext   (r_sign),
      .ld_raw        (bus_rdata),
      .ld_data       (w_ld_data)
   );

   assign w_access  = (mem_read_flag | mem_write_flag) & sel_is_legal(mem_sel);
   assign w_go      = (r_state == ST_IDLE) & w_access & ~w_misaligned;

   // bus_req and stall_req are decoded from state so an async reset drops them at once
   assign stall_req  = w_go | (r_state == ST_REQ);
   assign bus_req    = (r_state == ST_REQ);
   assign bus_we     = r_bus_we;
   assign bus_addr   = r_bus_addr;
   assign bus_be     = r_bus_be;
   assign bus_wdata  = r_bus_wdata;
   assign load_data  = r_load_data;
   assign load_valid = r_load_valid;
   assign addr_error = r_addr_error;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_load_data  <= '0;
         r_load_valid <= 1'b0;
         r_addr_error <= 1'b0;
         r_bus_we     <= 1'b0;
         r_bus_addr   <= '0;
         r_bus_be     <= 4'b0000;
         r_bus_wdata  <= '0;
         r_sel        <= '0;
         r_lane       <= 2'b00;
         r_sign       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         r_tmo_cnt    <= '0;
`endif
      end else begin
         r_load_valid <= 1'b0;
         r_addr_error <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_access && w_misaligned) begin
                  r_addr_error <= 1'b1;
               end else if (w_go) begin
                  r_bus_we    <= mem_write_flag;
                  r_bus_addr  <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                  r_bus_be    <= w_be;
                  r_bus_wdata <= w_wdata;
                  r_sel       <= mem_sel;
                  r_lane      <= mem_addr[1:0];
                  r_sign      <= mem_sign_ext_flag;
                  r_state     <= ST_REQ;
`ifdef MEM_TIMEOUT_EN
                  r_tmo_cnt   <= '0;
`endif
               end
            end
            ST_REQ: begin
               if (bus_ack) begin
                  if (!r_bus_we) begin
                     r_load_data  <= w_ld_data;
                     r_load_valid <= 1'b1;
                  end
                  r_state <= ST_DONE;
`ifdef MEM_TIMEOUT_EN
               end else if (r_tmo_cnt == c_tmo_last) begin
                  r_addr_error <= 1'b1;
                  r_state      <= ST_DONE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
               end
            end
            // The access that completed is still on the inputs here; never re-issue it
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule : data_mem_ctrl
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_data_mem_ctrl
// Brief    : Directed self-checking bench for data_mem_ctrl with a load-data
//            scoreboard. Timeout cases are exercised when MEM_TIMEOUT_EN is set.
// Revision : 1.0 - initial release
// =============================================================================
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read_flag, mem_write_flag, mem_sign_ext_flag;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr, mem_write_data;
   logic        stall_req, load_valid, addr_error, bus_req, bus_we;
   logic [31:0] load_data, bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;
   logic        bus_ack;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_lv    = 0;
   logic [31:0] sb_q[$];
   logic [31:0] last_load = 32'h0;

   data_mem_ctrl #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .mem_read_flag     (mem_read_flag),
      .mem_write_flag    (mem_write_flag),
      .mem_sign_ext_flag (mem_sign_ext_flag),
      .mem_sel           (mem_sel),
      .mem_addr          (mem_addr),
      .mem_write_data    (mem_write_data),
      .stall_req         (stall_req),
      .load_data         (load_data),
      .load_valid        (load_valid),
      .addr_error        (addr_error),
      .bus_req           (bus_req),
      .bus_we            (bus_we),
      .bus_addr          (bus_addr),
      .bus_be            (bus_be),
      .bus_wdata         (bus_wdata),
      .bus_ack           (bus_ack),
      .bus_rdata         (bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every load_valid pulse must match the oldest pushed expectation
   always @(negedge clk) begin
      if (load_valid === 1'b1) begin
         n_lv++;
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_underflow: observed load_valid with data %h, expected no pulse", load_data);
         end else begin
            chk("sb_load_data", load_data, sb_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic rd, input logic wr, input logic sx,
                         input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] wd);
      mem_read_flag     = rd;
      mem_write_flag    = wr;
      mem_sign_ext_flag = sx;
      mem_sel           = sel;
      mem_addr          = addr;
      mem_write_data    = wd;
   endtask

   // Aligned access with `waits` ack-wait cycles; called at posedge+1
   task automatic do_access(input string tag, input logic rd, input logic wr, input logic sx,
                            input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] wd,
                            input int waits, input logic [31:0] rdata,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_load);
      int n_stall;
      int lv0;
      logic is_load;
      is_load = rd & ~wr;
      lv0     = n_lv;
      n_stall = 0;
      if (is_load) begin
         sb_q.push_back(exp_load);
         last_load = exp_load;
      end
      set_in(rd, wr, sx, sel, addr, wd);
      @(negedge clk);
      chk({tag, "_idle_stall"}, {31'b0, stall_req}, 32'd1);
      chk({tag, "_idle_req"}, {31'b0, bus_req}, 32'd0);
      n_stall += int'(stall_req);
      step();
      for (int i = 0; i <= waits; i++) begin
         if (i == waits) begin
            bus_ack   = 1'b1;
            bus_rdata = rdata;
         end
         @(negedge clk);
         n_stall += int'(stall_req);
         chk({tag, "_req"}, {31'b0, bus_req}, 32'd1);
         if (i == 0) begin
            chk({tag, "_we"}, {31'b0, bus_we}, {31'b0, wr});
            chk({tag, "_addr"}, bus_addr, {addr[31:2], 2'b00});
            chk({tag, "_be"}, {28'b0, bus_be}, {28'b0, exp_be});
            if (wr) chk({tag, "_wdata"}, bus_wdata, exp_wdata);
         end
         step();
      end
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      @(negedge clk);
      chk({tag, "_done_stall"}, {31'b0, stall_req}, 32'd0);
      chk({tag, "_done_req"}, {31'b0, bus_req}, 32'd0);
      chk({tag, "_done_err"}, {31'b0, addr_error}, 32'd0);
      chk({tag, "_stall_cycles"}, n_stall, waits + 2);
      step();
      set_in(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
      @(negedge clk);
      chk({tag, "_no_reissue"}, {31'b0, bus_req}, 32'd0);
      #1;
      chk({tag, "_lv_pulses"}, n_lv - lv0, is_load ? 32'd1 : 32'd0);
      chk({tag, "_load_data_hold"}, load_data, last_load);
      step();
   endtask

   task automatic misaligned(input string tag, input logic [3:0] sel, input logic [31:0] addr);
      set_in(1'b1, 1'b0, 1'b0, sel, addr, 32'h0);
      @(negedge clk);
      chk({tag, "_stall"}, {31'b0, stall_req}, 32'd0);
      chk({tag, "_err_now"}, {31'b0, addr_error}, 32'd0);
      step();
      set_in(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
      @(negedge clk);
      chk({tag, "_err_pulse"}, {31'b0, addr_error}, 32'd1);
      chk({tag, "_no_req"}, {31'b0, bus_req}, 32'd0);
      step();
      @(negedge clk);
      chk({tag, "_err_clear"}, {31'b0, addr_error}, 32'd0);
      step();
   endtask

   initial begin
      rst       = 1'b1;
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      set_in(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", {31'b0, stall_req}, 32'd0);
      chk("rst_req", {31'b0, bus_req}, 32'd0);
      chk("rst_lv", {31'b0, load_valid}, 32'd0);
      chk("rst_err", {31'b0, addr_error}, 32'd0);
      chk("rst_we", {31'b0, bus_we}, 32'd0);
      chk("rst_be", {28'b0, bus_be}, 32'd0);
      chk("rst_wdata", bus_wdata, 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_load_data", load_data, 32'd0);
      step();
      rst = 1'b0;
      step();

      do_access("lw",  1, 0, 1, 4'b1111, 32'h100, 32'h0, 2, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
      do_access("lb",  1, 0, 1, 4'b0001, 32'h103, 32'h0, 0, 32'h80FFFFFF, 4'b1000, 32'h0, 32'hFFFFFF80);
      do_access("lbu", 1, 0, 0, 4'b0001, 32'h103, 32'h0, 1, 32'h80FFFFFF, 4'b1000, 32'h0, 32'h00000080);
      do_access("sh",  0, 1, 0, 4'b0011, 32'h102, 32'h00001234, 1, 32'hFFFFFFFF, 4'b1100, 32'h12341234, 32'h0);
      do_access("lh",  1, 0, 1, 4'b0011, 32'h102, 32'h0, 0, 32'h8001_7F00, 4'b1100, 32'h0, 32'hFFFF8001);
      do_access("lhu", 1, 0, 0, 4'b0011, 32'h200, 32'h0, 0, 32'h1234_9ABC, 4'b0011, 32'h0, 32'h00009ABC);
      do_access("sb",  0, 1, 0, 4'b0001, 32'h101, 32'h000000A5, 0, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'h0);
      do_access("rdwr", 1, 1, 0, 4'b1111, 32'h104, 32'hCAFEF00D, 0, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h0);

      misaligned("mis_lw", 4'b1111, 32'h101);
      misaligned("mis_lh", 4'b0011, 32'h103);

      // Reset while waiting for ack abandons the access
      set_in(1'b1, 1'b0, 1'b0, 4'b1111, 32'h180, 32'h0);
      step();
      @(negedge clk);
      chk("rst_mid_req_before", {31'b0, bus_req}, 32'd1);
      #1;
      rst = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
      #1;
      chk("rst_mid_req_drop", {31'b0, bus_req}, 32'd0);
      chk("rst_mid_stall_drop", {31'b0, stall_req}, 32'd0);
      step();
      rst       = 1'b0;
      bus_ack   = 1'b1;
      bus_rdata = 32'h55555555;
      @(negedge clk);
      chk("late_ack_req", {31'b0, bus_req}, 32'd0);
      step();
      bus_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_lv", {31'b0, load_valid}, 32'd0);
      chk("late_ack_load_data", load_data, 32'd0);
      last_load = 32'h0;
      step();
      do_access("lw_after_rst", 1, 0, 0, 4'b1111, 32'h240, 32'h0, 1, 32'h0BADF00D, 4'b1111, 32'h0, 32'h0BADF00D);

`ifdef MEM_TIMEOUT_EN
      set_in(1'b1, 1'b0, 1'b0, 4'b1111, 32'h300, 32'h0);
      step();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("tmo_req", {31'b0, bus_req}, 32'd1);
         chk("tmo_err_early", {31'b0, addr_error}, 32'd0);
         step();
      end
      @(negedge clk);
      chk("tmo_err", {31'b0, addr_error}, 32'd1);
      chk("tmo_stall", {31'b0, stall_req}, 32'd0);
      chk("tmo_load_data", load_data, last_load);
      step();
      set_in(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
      step();
      do_access("tmo_ack4", 1, 0, 0, 4'b1111, 32'h304, 32'h0, 3, 32'h13572468, 4'b1111, 32'h0, 32'h13572468);
`endif

      repeat (2) step();
      chk("sb_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_data_mem_ctrl
`default_nettype wire
